// File: rtl/disp_sched_if.sv
// rtl/disp_sched_if.sv - overlay request/acknowledge bundle for disp_sched
//
// Signals:
//   ovl_req   overlay request, single-cycle pulse from the overlay source
//   ovl_data  overlay digits, same packing as time_bcd, valid with ovl_req
//   ovl_ack   one-cycle pulse: request accepted and now on display
//   ovl_drop  one-cycle pulse: request discarded because the editor owns the display
// Modports: master = overlay source, slave = disp_sched.

interface disp_sched_if;
   logic        ovl_req;
   logic [23:0] ovl_data;
   logic        ovl_ack;
   logic        ovl_drop;

   modport master (
      output ovl_req,
      output ovl_data,
      input  ovl_ack,
      input  ovl_drop
   );

   modport slave (
      input  ovl_req,
      input  ovl_data,
      output ovl_ack,
      output ovl_drop
   );
endinterface

// File: rtl/disp_sched.sv
// rtl/disp_sched.sv - display source scheduler for the 6-digit seven-segment scan driver
//
// Picks what the display shows: live time of day, a timed overlay or the time
// editor (which blinks the field being edited). All outputs are registered.
//
// Ports:
//   clk, rst_n              system clock, asynchronous active-low reset
//   time_bcd[23:0]          background time, [3:0]=s0 ... [23:20]=h1
//   ovl                     overlay handshake (disp_sched_if.slave)
//   edit_active             level, editor owns the display
//   edit_data[23:0]         editor digits, same packing as time_bcd
//   edit_field[1:0]         0 none, 1 seconds, 2 minutes, 3 hours
//   s0,s1,m0,m1,h0,h1[3:0]  digits to the scan driver
//   disp_blank[5:0]         per-digit blank, bit0=s0 ... bit5=h1
//   mode[1:0]               0 TIME, 1 OVL, 2 EDIT

module disp_sched #(
   parameter int MS_CYCLES = 50000,
   parameter int OVL_MS    = 2000,
   parameter int BLINK_MS  = 500
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [23:0]  time_bcd,
   disp_sched_if.slave  ovl,
   input  logic         edit_active,
   input  logic [23:0]  edit_data,
   input  logic [1:0]   edit_field,
   output logic [3:0]   s0,
   output logic [3:0]   s1,
   output logic [3:0]   m0,
   output logic [3:0]   m1,
   output logic [3:0]   h0,
   output logic [3:0]   h1,
   output logic [5:0]   disp_blank,
   output logic [1:0]   mode
);

   localparam int MS_MAX = (OVL_MS > BLINK_MS) ? OVL_MS : BLINK_MS;
   localparam int MS_W   = $clog2(MS_MAX + 1);
   localparam int PRE_W  = $clog2(MS_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_TIME = 2'd0,
      ST_OVL  = 2'd1,
      ST_EDIT = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [PRE_W-1:0]   pre_q, pre_d;
   logic [MS_W-1:0]    ms_q, ms_d;
   logic               blink_q, blink_d;
   logic [23:0]        ovl_reg_q, ovl_reg_d;
   logic [1:0]         field_q, field_d;
   logic [23:0]        digits_q, digits_d;
   logic [5:0]         blank_q, blank_d;
   logic [1:0]         mode_q, mode_d;
   logic               ack_q, ack_d;
   logic               drop_q, drop_d;

   logic               tick;
   logic               accept;
   logic [PRE_W-1:0]   pre_run;
   logic [5:0]         field_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_TIME;
         pre_q     <= '0;
         ms_q      <= '0;
         blink_q   <= 1'b0;
         ovl_reg_q <= '0;
         field_q   <= '0;
         digits_q  <= '0;
         blank_q   <= '0;
         mode_q    <= '0;
         ack_q     <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         ms_q      <= ms_d;
         blink_q   <= blink_d;
         ovl_reg_q <= ovl_reg_d;
         field_q   <= field_d;
         digits_q  <= digits_d;
         blank_q   <= blank_d;
         mode_q    <= mode_d;
         ack_q     <= ack_d;
         drop_q    <= drop_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pre_d      = pre_q;
      ms_d       = ms_q;
      blink_d    = blink_q;
      ovl_reg_d  = ovl_reg_q;
      field_d    = edit_field;
      accept     = 1'b0;
      tick       = (pre_q == PRE_W'(MS_CYCLES - 1));
      pre_run    = tick ? '0 : pre_q + PRE_W'(1);
      field_mask = 6'b000000;

      // Any request while the editor is active is refused, including the
      // cycle edit_active rises.
      drop_d     = ovl.ovl_req & edit_active;

      case (state_q)
         ST_TIME: begin
            if (edit_active) begin
               state_d = ST_EDIT;
               pre_d   = '0;
               ms_d    = '0;
               blink_d = 1'b0;
            end else if (ovl.ovl_req) begin
               state_d = ST_OVL;
               accept  = 1'b1;
            end else begin
               pre_d   = pre_run;
            end
         end
         ST_OVL: begin
            if (edit_active) begin
               state_d = ST_EDIT;
               pre_d   = '0;
               ms_d    = '0;
               blink_d = 1'b0;
            end else if (ovl.ovl_req) begin
               accept  = 1'b1;
            end else begin
               pre_d = pre_run;
               if (tick) begin
                  if (ms_q == MS_W'(OVL_MS - 1)) begin
                     state_d = ST_TIME;
                     ms_d    = '0;
                  end else begin
                     ms_d = ms_q + MS_W'(1);
                  end
               end
            end
         end
         ST_EDIT: begin
            if (!edit_active) begin
               // Leaving the editor never resumes an abandoned overlay.
               state_d = ST_TIME;
               pre_d   = '0;
               ms_d    = '0;
               blink_d = 1'b0;
            end else if (edit_field != field_q) begin
               // Restart the blink so the newly selected field shows first.
               pre_d   = '0;
               ms_d    = '0;
               blink_d = 1'b0;
            end else begin
               pre_d = pre_run;
               if (tick) begin
                  if (ms_q == MS_W'(BLINK_MS - 1)) begin
                     ms_d    = '0;
                     blink_d = ~blink_q;
                  end else begin
                     ms_d = ms_q + MS_W'(1);
                  end
               end
            end
         end
         default: begin
            state_d = ST_TIME;
            pre_d   = '0;
            ms_d    = '0;
            blink_d = 1'b0;
         end
      endcase

      // Accept and retrigger both restart the full hold period.
      if (accept) begin
         ovl_reg_d = ovl.ovl_data;
         pre_d     = '0;
         ms_d      = '0;
      end

      case (edit_field)
         2'd1:    field_mask = 6'b000011;
         2'd2:    field_mask = 6'b001100;
         2'd3:    field_mask = 6'b110000;
         default: field_mask = 6'b000000;
      endcase

      // Output registers reflect the decision taken at this edge.
      case (state_d)
         ST_OVL:  digits_d = ovl_reg_d;
         ST_EDIT: digits_d = edit_data;
         default: digits_d = time_bcd;
      endcase
      blank_d = ((state_d == ST_EDIT) && blink_d) ? field_mask : 6'b000000;
      mode_d  = 2'(state_d);
      ack_d   = accept;
   end

   assign s0           = digits_q[3:0];
   assign s1           = digits_q[7:4];
   assign m0           = digits_q[11:8];
   assign m1           = digits_q[15:12];
   assign h0           = digits_q[19:16];
   assign h1           = digits_q[23:20];
   assign disp_blank   = blank_q;
   assign mode         = mode_q;
   assign ovl.ovl_ack  = ack_q;
   assign ovl.ovl_drop = drop_q;

endmodule

// File: tb/tb_disp_sched.sv
// tb/tb_disp_sched.sv - self-checking bench for disp_sched with a cycle-count reference model

module tb_disp_sched;

   localparam int MSC   = 4;
   localparam int OVLM  = 3;
   localparam int BLKM  = 2;
   localparam int OVL_CYC = OVLM * MSC;
   localparam int BLK_CYC = BLKM * MSC;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] time_bcd;
   logic        edit_active;
   logic [23:0] edit_data;
   logic [1:0]  edit_field;
   logic [3:0]  s0, s1, m0, m1, h0, h1;
   logic [5:0]  disp_blank;
   logic [1:0]  mode;

   disp_sched_if ovl_if ();

   disp_sched #(.MS_CYCLES(MSC), .OVL_MS(OVLM), .BLINK_MS(BLKM)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .time_bcd    (time_bcd),
      .ovl         (ovl_if),
      .edit_active (edit_active),
      .edit_data   (edit_data),
      .edit_field  (edit_field),
      .s0          (s0),
      .s1          (s1),
      .m0          (m0),
      .m1          (m1),
      .h0          (h0),
      .h1          (h1),
      .disp_blank  (disp_blank),
      .mode        (mode)
   );

   always #5 clk = ~clk;

   wire [23:0] dut_digits = {h1, h0, m1, m0, s1, s0};

   int n_chk  = 0;
   int n_fail = 0;
   logic check_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: which source owns the display, how many cycles of the
   // overlay hold remain, and how many cycles since the blink was restarted.
   int          m_mode;
   int          m_left;
   int          m_cnt;
   logic [23:0] m_ovl;
   logic [1:0]  m_prev;
   logic [23:0] e_digits;
   logic [5:0]  e_blank;
   logic [1:0]  e_mode;
   logic        e_ack, e_drop;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode   <= 0;
         m_left   <= 0;
         m_cnt    <= 0;
         m_ovl    <= '0;
         m_prev   <= '0;
         e_digits <= '0;
         e_blank  <= '0;
         e_mode   <= '0;
         e_ack    <= 1'b0;
         e_drop   <= 1'b0;
      end else begin
         int nm, nl, nc;
         logic [23:0] no;
         logic acc;
         logic [5:0] mask;
         nm = m_mode; nl = m_left; nc = m_cnt; no = m_ovl; acc = 1'b0;
         if (m_mode == 2) begin
            if (!edit_active) nm = 0;
            else if (edit_field != m_prev) nc = 0;
            else nc = m_cnt + 1;
         end else if (edit_active) begin
            nm = 2; nc = 0;
         end else if (ovl_if.ovl_req) begin
            nm = 1; no = ovl_if.ovl_data; nl = OVL_CYC; acc = 1'b1;
         end else if (m_mode == 1) begin
            nl = m_left - 1;
            if (nl == 0) nm = 0;
         end
         mask = (edit_field == 2'd1) ? 6'h03 : (edit_field == 2'd2) ? 6'h0C :
                (edit_field == 2'd3) ? 6'h30 : 6'h00;
         m_mode   <= nm;
         m_left   <= nl;
         m_cnt    <= nc;
         m_ovl    <= no;
         m_prev   <= edit_field;
         e_digits <= (nm == 1) ? no : (nm == 2) ? edit_data : time_bcd;
         e_blank  <= (nm == 2 && ((nc / BLK_CYC) % 2) == 1) ? mask : 6'h00;
         e_mode   <= 2'(nm);
         e_ack    <= acc;
         e_drop   <= ovl_if.ovl_req & edit_active;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("model_digits", {8'h0, dut_digits}, {8'h0, e_digits});
         chk("model_blank", {26'h0, disp_blank}, {26'h0, e_blank});
         chk("model_mode", {30'h0, mode}, {30'h0, e_mode});
         chk("model_ack", {31'h0, ovl_if.ovl_ack}, {31'h0, e_ack});
         chk("model_drop", {31'h0, ovl_if.ovl_drop}, {31'h0, e_drop});
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      time_bcd = '0; edit_active = 1'b0; edit_data = '0; edit_field = '0;
      ovl_if.ovl_req = 1'b0; ovl_if.ovl_data = '0;
      check_en = 1'b1;
      tick(3);
      chk("reset_digits", {8'h0, dut_digits}, 32'h0);
      chk("reset_mode", {30'h0, mode}, 32'h0);
      chk("reset_blank", {26'h0, disp_blank}, 32'h0);
      rst_n = 1'b1;

      // pass-through
      time_bcd = 24'h235959;
      tick();
      chk("pass_h1", {28'h0, h1}, 32'd2);
      chk("pass_h0", {28'h0, h0}, 32'd3);
      chk("pass_m1", {28'h0, m1}, 32'd5);
      chk("pass_m0", {28'h0, m0}, 32'd9);
      chk("pass_s1", {28'h0, s1}, 32'd5);
      chk("pass_s0", {28'h0, s0}, 32'd9);
      chk("pass_mode", {30'h0, mode}, 32'd0);

      // overlay and expiry at k+12
      ovl_if.ovl_req = 1'b1; ovl_if.ovl_data = 24'h000075;
      tick();
      ovl_if.ovl_req = 1'b0;
      chk("ovl_ack_on", {31'h0, ovl_if.ovl_ack}, 32'd1);
      chk("ovl_digits", {8'h0, dut_digits}, 32'h000075);
      chk("ovl_mode", {30'h0, mode}, 32'd1);
      tick();
      chk("ovl_ack_off", {31'h0, ovl_if.ovl_ack}, 32'd0);
      tick(10);
      chk("ovl_hold_k11", {30'h0, mode}, 32'd1);
      tick();
      chk("ovl_exp_k12", {30'h0, mode}, 32'd0);
      chk("ovl_exp_digits", {8'h0, dut_digits}, 32'h235959);

      // retrigger at k+8 moves expiry to k+20
      ovl_if.ovl_req = 1'b1; ovl_if.ovl_data = 24'h000075;
      tick();
      ovl_if.ovl_req = 1'b0;
      tick(7);
      ovl_if.ovl_req = 1'b1; ovl_if.ovl_data = 24'h000050;
      tick();
      ovl_if.ovl_req = 1'b0;
      chk("retrig_digits", {8'h0, dut_digits}, 32'h000050);
      tick(11);
      chk("retrig_hold_k19", {30'h0, mode}, 32'd1);
      tick();
      chk("retrig_exp_k20", {30'h0, mode}, 32'd0);

      // edit preempts overlay and blinks
      ovl_if.ovl_req = 1'b1; ovl_if.ovl_data = 24'h000033;
      tick();
      ovl_if.ovl_req = 1'b0;
      tick(2);
      edit_active = 1'b1; edit_field = 2'd2; edit_data = 24'h123456;
      tick();
      chk("edit_mode", {30'h0, mode}, 32'd2);
      chk("edit_digits", {8'h0, dut_digits}, 32'h123456);
      chk("blink_e0", {26'h0, disp_blank}, 32'h00);
      tick(7);
      chk("blink_e7", {26'h0, disp_blank}, 32'h00);
      tick();
      chk("blink_e8", {26'h0, disp_blank}, 32'h0C);
      tick(7);
      chk("blink_e15", {26'h0, disp_blank}, 32'h0C);
      tick();
      chk("blink_e16", {26'h0, disp_blank}, 32'h00);
      tick(8);
      chk("blink_e24", {26'h0, disp_blank}, 32'h0C);
      edit_field = 2'd3;
      tick();
      chk("field_chg", {26'h0, disp_blank}, 32'h00);
      tick(7);
      chk("field_c7", {26'h0, disp_blank}, 32'h00);
      tick();
      chk("field_c8", {26'h0, disp_blank}, 32'h30);
      edit_active = 1'b0;
      tick();
      chk("edit_exit_mode", {30'h0, mode}, 32'd0);
      chk("edit_exit_blank", {26'h0, disp_blank}, 32'h00);
      chk("edit_exit_digits", {8'h0, dut_digits}, 32'h235959);

      // simultaneous request and edit entry
      edit_active = 1'b1; ovl_if.ovl_req = 1'b1; ovl_if.ovl_data = 24'h000099;
      tick();
      ovl_if.ovl_req = 1'b0;
      chk("simul_mode", {30'h0, mode}, 32'd2);
      chk("simul_drop", {31'h0, ovl_if.ovl_drop}, 32'd1);
      chk("simul_ack", {31'h0, ovl_if.ovl_ack}, 32'd0);
      tick();
      chk("simul_drop_off", {31'h0, ovl_if.ovl_drop}, 32'd0);
      edit_active = 1'b0;
      tick();
      chk("simul_exit_mode", {30'h0, mode}, 32'd0);
      chk("simul_exit_digits", {8'h0, dut_digits}, 32'h235959);

      // reset mid-overlay
      ovl_if.ovl_req = 1'b1; ovl_if.ovl_data = 24'h000042;
      tick();
      ovl_if.ovl_req = 1'b0;
      tick(4);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_digits", {8'h0, dut_digits}, 32'h0);
      chk("rst_mid_mode", {30'h0, mode}, 32'd0);
      chk("rst_mid_ack", {31'h0, ovl_if.ovl_ack}, 32'd0);
      tick(2);
      rst_n = 1'b1;
      time_bcd = 24'h101112;
      tick();
      chk("rst_resume", {8'h0, dut_digits}, 32'h101112);
      chk("rst_resume_mode", {30'h0, mode}, 32'd0);

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         time_bcd       = 24'($urandom);
         edit_data      = 24'($urandom);
         ovl_if.ovl_data = 24'($urandom);
         ovl_if.ovl_req = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 59) == 0) edit_active = ~edit_active;
         if ($urandom_range(0, 29) == 0) edit_field = 2'($urandom_range(0, 3));
         rst_n = ($urandom_range(0, 799) != 0);
         tick();
      end
      rst_n = 1'b1;
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/disp_sched.md
# disp_sched

Display scheduler that decides what the 6-digit multiplexed seven-segment display shows. The normal source is the running time of day. It can be overridden by a timed overlay, such as a PWM duty or FM channel readout pushed by another block, or by the time-setting editor, which also blinks the field being edited. The block sits directly upstream of the digit-scan driver. It supplies its six BCD digit inputs plus a per-digit blank mask, which the top level ANDs into the digit selects.

## Interface
- MS_CYCLES, 50000: clk cycles per 1 ms tick (50 MHz).
- OVL_MS, 2000: overlay hold time in ms.
- BLINK_MS, 500: blink half-period in ms.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- time_bcd  in  24  background time; packing [3:0]=s0, [7:4]=s1, [11:8]=m0, [15:12]=m1, [19:16]=h0, [23:20]=h1.
- ovl_req  in  1  single-cycle overlay request.
- ovl_data  in  24  overlay digits, same packing; sampled with ovl_req.
- edit_active  in  1  level; time editor owns the display.
- edit_data  in  24  editor digits, same packing.
- edit_field  in  2  0 none, 1 seconds, 2 minutes, 3 hours.
- s0, s1, m0, m1, h0, h1  out  4 each  registered digits to the scan driver.
- disp_blank  out  6  registered; bit i=1 blanks digit i (bit0=s0 … bit5=h1).
- mode  out  2  0 TIME, 1 OVL, 2 EDIT.
- ovl_ack  out  1  one-cycle pulse: request accepted.
- ovl_drop  out  1  one-cycle pulse: request discarded.

## Operation
- The FSM has states TIME, OVL and EDIT. Priority is EDIT > OVL > TIME.
- Transitions out of TIME:
  - edit_active=1 → EDIT.
  - ovl_req=1 → OVL.
- Transitions out of OVL:
  - edit_active=1 → EDIT; the overlay is abandoned and its timer is cleared.
  - ovl_req=1 → stay in OVL (retrigger).
  - Timer expiry → TIME.
- Transitions out of EDIT:
  - edit_active=0 → TIME. Never resume a prior overlay.
- Overlay accept happens in TIME or OVL with edit_active=0. On accept:
  - ovl_data is captured into the overlay register.
  - The ms prescaler and the ms counter are cleared.
  - ovl_ack is pulsed.
- A retrigger during OVL recaptures ovl_data and restarts the full OVL_MS period.
- ovl_req with edit_active=1, including the cycle edit_active rises, is discarded and ovl_drop is pulsed.
- Prescaler: counts 0..MS_CYCLES-1 and emits a tick on MS_CYCLES-1. It is cleared on overlay accept, on EDIT entry and on edit_field change while in EDIT.
- ms counter: width is clog2(max(OVL_MS, BLINK_MS)+1). It increments on each tick.
  - In OVL it expires at OVL_MS.
  - In EDIT it wraps at BLINK_MS and toggles blink_phase.
- Blink:
  - blink_phase=0 on EDIT entry and on any edit_field change.
  - blink_phase=0 means visible; 1 means the selected field is blanked.
  - Field 1 blanks bits [1:0], field 2 blanks [3:2], field 3 blanks [5:4], field 0 blanks nothing.
- Digit source by state: TIME → time_bcd (live, every cycle), OVL → overlay register, EDIT → edit_data (live).
- Digits pass through unmodified. No BCD range checking is done.
- disp_blank is 0 in TIME and OVL.

## Timing
- Reset values: state TIME, all digits 0, disp_blank 0, mode 0, ovl_ack 0, ovl_drop 0, prescaler 0, ms counter 0, blink_phase 0.
- Output latency is 1 cycle. The outputs after edge k reflect the next-state decision and source sampled at edge k.
  - Example: ovl_req high at edge k gives, after edge k, mode=1, digits=ovl_data and ovl_ack=1 for that one cycle.
- Overlay duration is exactly OVL_MS·MS_CYCLES cycles. mode returns to 0 after edge k+OVL_MS·MS_CYCLES, with no further request.
- A blink toggle occurs every BLINK_MS·MS_CYCLES cycles after EDIT entry or field change.
- Falling edit_active at edge k: after edge k, mode=0, disp_blank=0 and digits=time_bcd.
- Reset asserted mid-operation returns everything to the reset values immediately. A pending overlay is lost and no ack/drop is emitted.

## Test plan
Benches use MS_CYCLES=4, OVL_MS=3 and BLINK_MS=2.
- **Pass-through:** after reset, drive time_bcd=0x235959 → one cycle later the digits read h1=2, h0=3, m1=5, m0=9, s1=5, s0=9; mode=0; disp_blank=0.
- **Overlay and expiry:** ovl_req with ovl_data=0x000075 at edge k → ovl_ack is high for exactly 1 cycle and the digits show 000075. After edge k+12, mode=0 and time digits return.
- **Retrigger:** a second ovl_req with 0x000050 at edge k+8 → digits become 000050 and expiry moves to edge k+20.
- **Edit preempts overlay, blink:** edit_active=1 with edit_field=2 during OVL → mode=2 next cycle. disp_blank=000000 for 8 cycles, then 001100 for 8 cycles, then repeats. Changing edit_field to 3 mid-blank gives disp_blank=000000, with a blank of 110000 8 cycles later.
- **Simultaneous:** ovl_req on the same edge edit_active rises → mode=2, ovl_drop pulses once, ovl_ack stays 0. Dropping edit_active → mode=0, with no overlay shown.
- **Reset mid-overlay:** assert rst_n=0 at 5 cycles into OVL → outputs go immediately to zeros and mode=0. After release, time pass-through resumes.
